// File: rtl/bin2bcd_pkg.sv
// Shared widths, constants, tag type and binary-to-BCD helper for the bin2bcd blocks.
package bin2bcd_pkg;

  localparam int unsigned BIN_W = 11;
  localparam int unsigned BCD_W = 17;
  localparam int unsigned DIG_W = 16;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [BIN_W-1:0] BIN_NEG_MAX = 11'h400;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Signed 11-bit to {sign, 4 BCD digits} via shift-and-add-3.
  function automatic logic [BCD_W-1:0] bin_to_bcd(input logic [BIN_W-1:0] bin);
    logic [BIN_W-1:0] mag;
    logic [DIG_W-1:0] bcd;
    mag = bin[BIN_W-1] ? BIN_W'(-bin) : bin;
    bcd = '0;
    for (int i = BIN_W - 1; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) begin
          bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
      end
      bcd = {bcd[DIG_W-2:0], mag[i]};
    end
    return {bin[BIN_W-1], bcd};
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Pipelined signed binary to BCD converter; conversion in the first stage,
// result delayed through PIPE_STAGE register stages in total.
module bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int unsigned PIPE_STAGE = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_vld,
  input  logic [BIN_W-1:0] in_bin,
  output logic             out_vld,
  output logic [BCD_W-1:0] out_bcd
);

  logic [PIPE_STAGE-1:0]            vld_d, vld_q;
  logic [PIPE_STAGE-1:0][BCD_W-1:0] bcd_d, bcd_q;

  always_comb begin
    vld_d    = '0;
    bcd_d    = '0;
    vld_d[0] = in_vld;
    bcd_d[0] = bin_to_bcd(in_bin);
    for (int s = 1; s < int'(PIPE_STAGE); s++) begin
      vld_d[s] = vld_q[s-1];
      bcd_d[s] = bcd_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      bcd_q <= '0;
    end else begin
      vld_q <= vld_d;
      bcd_q <= bcd_d;
    end
  end

  assign out_vld = vld_q[PIPE_STAGE-1];
  assign out_bcd = bcd_q[PIPE_STAGE-1];

endmodule

// File: rtl/bin2bcd_sched.sv
// Round-robin scheduler sharing one bin2bcd converter among NREQ requesters,
// with a tag pipeline tracking result ownership.
// Optional BIN2BCD_SCHED_STAT_EN adds saturating per-requester grant counters on stat_gnt.
module bin2bcd_sched
  import bin2bcd_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*BIN_W-1:0] req_bin,
  output logic [NREQ-1:0]       req_rdy,
  output logic                  rsp_vld,
  output logic [ID_W-1:0]       rsp_id,
  output logic [BCD_W-1:0]      rsp_bcd,
  output logic                  err
`ifdef BIN2BCD_SCHED_STAT_EN
  ,
  output logic [NREQ*CNT_W-1:0] stat_gnt
`endif
);

  logic [ID_W-1:0]  ptr_d, ptr_q;
  logic [7:0]       vld_ext;
  logic [ID_W-1:0]  cand;
  logic             gnt_any;
  logic [ID_W-1:0]  gnt_id;
  logic [BIN_W-1:0] bin_sel;
  logic [BIN_W-1:0] bin_cv;
  tag_t [LAT-1:0]   tag_d, tag_q;
  logic             err_d, err_q;
  logic             cv_vld;
  logic [BCD_W-1:0] cv_bcd;

  // Search starts one past the last granted requester and wraps.
  always_comb begin
    vld_ext = 8'(req_vld);
    cand    = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = ID_W'((int'(ptr_q) + 1 + k) % int'(NREQ));
      if (!gnt_any && vld_ext[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    bin_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_id == ID_W'(i)) begin
        req_rdy[i] = gnt_any & rstn;
        bin_sel    = req_bin[i*BIN_W +: BIN_W];
      end
    end
    bin_cv = (bin_sel == BIN_NEG_MAX) ? '0 : bin_sel;
    ptr_d  = gnt_any ? gnt_id : ptr_q;
  end

  // Tag pipeline runs in lockstep with the converter stages.
  always_comb begin
    tag_d          = '0;
    tag_d[0].valid = gnt_any;
    tag_d[0].id    = gnt_id;
    for (int s = 1; s < int'(LAT); s++) begin
      tag_d[s] = tag_q[s-1];
    end
    err_d = err_q | (cv_vld != tag_q[LAT-1].valid);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= ID_W'(NREQ - 1);
      tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
      err_q <= err_d;
    end
  end

  bin2bcd #(
    .PIPE_STAGE(LAT)
  ) u_cv (
    .clk    (clk),
    .rstn   (rstn),
    .in_vld (gnt_any),
    .in_bin (bin_cv),
    .out_vld(cv_vld),
    .out_bcd(cv_bcd)
  );

  assign rsp_vld = tag_q[LAT-1].valid;
  assign rsp_id  = tag_q[LAT-1].id;
  assign rsp_bcd = cv_bcd;
  assign err     = err_q;

`ifdef BIN2BCD_SCHED_STAT_EN
  logic [NREQ-1:0][CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_any && gnt_id == ID_W'(i) && cnt_q[i] != {CNT_W{1'b1}}) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_gnt = cnt_q;
`endif

endmodule
